// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: bus widths,
// the reset PC, the NOP filler instruction and the fetch FSM encoding.
`timescale 1ns/1ps
package inst_fetch_pkg;

  typedef logic [31:0] AddrBus;
  typedef logic [31:0] InstBus;

  localparam AddrBus ZeroPc  = 32'h0000_0000;
  localparam InstBus InstNop = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_RESP = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  // Fetches are word-aligned; redirect targets have their low two bits dropped.
  function automatic AddrBus align_word(input AddrBus a);
    return a & ~32'd3;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory port of the fetch stage: one request/grant handshake and
// an in-order read response.
`timescale 1ns/1ps
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  // Handshake: a request transfers on a cycle where o_MEM_req and i_MEM_gnt are
  // both high. i_MEM_rvalid is a one-cycle strobe returning i_MEM_rdata for the
  // oldest granted request, at least one cycle after its grant.
  logic   o_MEM_req;
  AddrBus o_MEM_addr;
  logic   i_MEM_gnt;
  logic   i_MEM_rvalid;
  InstBus i_MEM_rdata;

  modport master (
    output o_MEM_req,
    output o_MEM_addr,
    input  i_MEM_gnt,
    input  i_MEM_rvalid,
    input  i_MEM_rdata
  );

  modport slave (
    input  o_MEM_req,
    input  o_MEM_addr,
    output i_MEM_gnt,
    output i_MEM_rvalid,
    output i_MEM_rdata
  );

endinterface

// File: rtl/inst_fetch.sv
// Single-outstanding instruction fetch stage with a one-entry hold buffer.
// Optional FETCH_PERF_EN adds consumed-instruction and stall-cycle counters.
`timescale 1ns/1ps
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter AddrBus RESET_PC = ZeroPc
) (
  input  logic         clk,
  input  logic         rst,
  output AddrBus       o_IF_pc,
  output InstBus       o_IF_inst,
  output logic         o_IF_valid,
  input  logic         i_IDSUE_wait,
  input  logic         i_EX_redirect,
  input  AddrBus       i_EX_target,
  inst_fetch_if.master mem,
  output fetch_state_e o_dbg_state
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  o_PERF_fetched,
  output logic [31:0]  o_PERF_stall
`endif
);

  fetch_state_e r_state, w_state_nxt;
  AddrBus       r_pc, w_pc_nxt;
  AddrBus       r_resp_pc, w_resp_pc_nxt;
  logic         r_discard, w_discard_nxt;
  AddrBus       r_hold_pc, w_hold_pc_nxt;
  InstBus       r_hold_inst, w_hold_inst_nxt;
  AddrBus       r_if_pc, w_if_pc_nxt;
  InstBus       r_if_inst, w_if_inst_nxt;
  logic         r_if_valid, w_if_valid_nxt;

  logic w_mem_req;
  logic w_out_free;
  logic w_outstanding;

  // Requests are held off while reset is asserted even though state is REQ.
  assign w_mem_req     = (r_state == S_REQ) && rst;
  assign w_out_free    = !r_if_valid || !i_IDSUE_wait;
  assign w_outstanding = ((r_state == S_RESP) && !mem.i_MEM_rvalid) ||
                         (w_mem_req && mem.i_MEM_gnt);

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_resp_pc_nxt   = r_resp_pc;
    w_discard_nxt   = r_discard;
    w_hold_pc_nxt   = r_hold_pc;
    w_hold_inst_nxt = r_hold_inst;
    w_if_pc_nxt     = r_if_pc;
    w_if_inst_nxt   = r_if_inst;
    w_if_valid_nxt  = r_if_valid;

    // Consumed output turns into a bubble unless something new is loaded below.
    if (!i_IDSUE_wait) begin
      w_if_valid_nxt = 1'b0;
      w_if_inst_nxt  = InstNop;
    end

    unique case (r_state)
      S_REQ: begin
        if (w_mem_req && mem.i_MEM_gnt) begin
          w_state_nxt   = S_RESP;
          w_resp_pc_nxt = r_pc;
          w_pc_nxt      = r_pc + 32'd4;
        end
      end
      S_RESP: begin
        if (mem.i_MEM_rvalid) begin
          w_state_nxt = S_REQ;
          if (r_discard) begin
            w_discard_nxt = 1'b0;
          end else if (w_out_free) begin
            w_if_pc_nxt    = r_resp_pc;
            w_if_inst_nxt  = mem.i_MEM_rdata;
            w_if_valid_nxt = 1'b1;
          end else begin
            w_hold_pc_nxt   = r_resp_pc;
            w_hold_inst_nxt = mem.i_MEM_rdata;
            w_state_nxt     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (w_out_free) begin
          w_if_pc_nxt    = r_hold_pc;
          w_if_inst_nxt  = r_hold_inst;
          w_if_valid_nxt = 1'b1;
          w_state_nxt    = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase

    // Redirect overrides everything; a response still owed by memory is
    // tracked with the discard flag so it is not mistaken for the new stream.
    if (i_EX_redirect) begin
      w_pc_nxt       = align_word(i_EX_target);
      w_if_valid_nxt = 1'b0;
      w_if_inst_nxt  = InstNop;
      w_discard_nxt  = w_outstanding;
      w_state_nxt    = w_outstanding ? S_RESP : S_REQ;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_REQ;
      r_pc        <= RESET_PC;
      r_resp_pc   <= ZeroPc;
      r_discard   <= 1'b0;
      r_hold_pc   <= ZeroPc;
      r_hold_inst <= InstNop;
      r_if_pc     <= ZeroPc;
      r_if_inst   <= InstNop;
      r_if_valid  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_resp_pc   <= w_resp_pc_nxt;
      r_discard   <= w_discard_nxt;
      r_hold_pc   <= w_hold_pc_nxt;
      r_hold_inst <= w_hold_inst_nxt;
      r_if_pc     <= w_if_pc_nxt;
      r_if_inst   <= w_if_inst_nxt;
      r_if_valid  <= w_if_valid_nxt;
    end
  end

  assign o_IF_pc        = r_if_pc;
  assign o_IF_inst      = r_if_inst;
  assign o_IF_valid     = r_if_valid;
  assign o_dbg_state    = r_state;
  assign mem.o_MEM_req  = w_mem_req;
  assign mem.o_MEM_addr = r_pc;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_fetched <= 32'd0;
      r_perf_stall   <= 32'd0;
    end else begin
      r_perf_fetched <= r_perf_fetched + {31'd0, (r_if_valid && !i_IDSUE_wait)};
      r_perf_stall   <= r_perf_stall + {31'd0, (r_if_valid && i_IDSUE_wait)};
    end
  end

  assign o_PERF_fetched = r_perf_fetched;
  assign o_PERF_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: memory responder with programmable latency, an
// in-order scoreboard of consumed instructions, and one task per scenario.
`timescale 1ns/1ps
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         idsue_wait;
  logic         redirect;
  AddrBus       target;
  AddrBus       if_pc;
  InstBus       if_inst;
  logic         if_valid;
  fetch_state_e dbg_state;
  AddrBus       w_if_pc;
  InstBus       w_if_inst;
  logic         w_if_valid;
  fetch_state_e w_dbg_state;
`ifdef FETCH_PERF_EN
  logic [31:0]  perf_fetched, perf_stall, w_perf_fetched, w_perf_stall;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] exp_q[$];

  int     mem_lat = 1;
  bit     pend = 1'b0;
  int     cnt = 0;
  AddrBus paddr;

  inst_fetch_if mem_m();
  inst_fetch_if mem_w();

  inst_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .o_IF_pc       (if_pc),
    .o_IF_inst     (if_inst),
    .o_IF_valid    (if_valid),
    .i_IDSUE_wait  (idsue_wait),
    .i_EX_redirect (redirect),
    .i_EX_target   (target),
    .mem           (mem_m),
    .o_dbg_state   (dbg_state)
`ifdef FETCH_PERF_EN
    ,
    .o_PERF_fetched(perf_fetched),
    .o_PERF_stall  (perf_stall)
`endif
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk           (clk),
    .rst           (rst),
    .o_IF_pc       (w_if_pc),
    .o_IF_inst     (w_if_inst),
    .o_IF_valid    (w_if_valid),
    .i_IDSUE_wait  (1'b0),
    .i_EX_redirect (1'b0),
    .i_EX_target   (32'h0),
    .mem           (mem_w),
    .o_dbg_state   (w_dbg_state)
`ifdef FETCH_PERF_EN
    ,
    .o_PERF_fetched(w_perf_fetched),
    .o_PERF_stall  (w_perf_stall)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  function automatic InstBus inst_of(input AddrBus a);
    return 32'hA000_0000 ^ a;
  endfunction

  task automatic apply_reset(input int lat);
    rst        = 1'b0;
    redirect   = 1'b0;
    target     = 32'h0;
    idsue_wait = 1'b0;
    mem_lat    = lat;
    mem_m.i_MEM_gnt = 1'b1;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic push_exp(input AddrBus pc);
    exp_q.push_back({pc, inst_of(pc)});
  endtask

  task automatic drain(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
        idsue_wait = 1'b1;
        ok = 1'b1;
        break;
      end
    end
    idsue_wait = 1'b1;
  endtask

  // ---------------- memory drivers ----------------
  initial begin : mem_main
    bit     g;
    AddrBus ga;
    mem_m.i_MEM_gnt    = 1'b1;
    mem_m.i_MEM_rvalid = 1'b0;
    mem_m.i_MEM_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      g  = mem_m.o_MEM_req && mem_m.i_MEM_gnt;
      ga = mem_m.o_MEM_addr;
      @(posedge clk); #1;
      mem_m.i_MEM_rvalid = 1'b0;
      if (!rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            mem_m.i_MEM_rvalid = 1'b1;
            mem_m.i_MEM_rdata  = inst_of(paddr);
            pend = 1'b0;
          end
        end
        if (g) begin
          if (mem_lat <= 1) begin
            mem_m.i_MEM_rvalid = 1'b1;
            mem_m.i_MEM_rdata  = inst_of(ga);
          end else begin
            pend  = 1'b1;
            cnt   = mem_lat - 1;
            paddr = ga;
          end
        end
      end
    end
  end

  initial begin : mem_wrap
    bit     wg;
    AddrBus wa;
    mem_w.i_MEM_gnt    = 1'b1;
    mem_w.i_MEM_rvalid = 1'b0;
    mem_w.i_MEM_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      wg = mem_w.o_MEM_req && mem_w.i_MEM_gnt;
      wa = mem_w.o_MEM_addr;
      @(posedge clk); #1;
      mem_w.i_MEM_rvalid = wg && rst;
      mem_w.i_MEM_rdata  = wa;
    end
  end

  // ---------------- scoreboard: every consumed instruction ----------------
  initial begin : monitor
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst && if_valid && !idsue_wait) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected got pc=%h inst=%h, expected nothing", if_pc, if_inst);
        end else begin
          e = exp_q.pop_front();
          if ({if_pc, if_inst} !== e)
            $display("FAIL sb_order got pc=%h inst=%h, expected pc=%h inst=%h",
                     if_pc, if_inst, e[63:32], e[31:0]);
          else
            n_pass++;
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    mem_m.i_MEM_gnt = 1'b1;
    idsue_wait = 1'b1;
    redirect   = 1'b0;
    target     = 32'h0;
    rst        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (if_pc !== ZeroPc) $display("FAIL rst_pc got %h expected %h", if_pc, ZeroPc); else n_pass++;
    n_checks++; if (if_inst !== InstNop) $display("FAIL rst_inst got %h expected %h", if_inst, InstNop); else n_pass++;
    n_checks++; if (if_valid !== 1'b0) $display("FAIL rst_valid got %b expected 0", if_valid); else n_pass++;
    n_checks++; if (mem_m.o_MEM_req !== 1'b0) $display("FAIL rst_req got %b expected 0", mem_m.o_MEM_req); else n_pass++;
    n_checks++; if (dbg_state !== S_REQ) $display("FAIL rst_state got %0d expected %0d", dbg_state, S_REQ); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (mem_m.o_MEM_req !== 1'b1) $display("FAIL first_req got %b expected 1", mem_m.o_MEM_req); else n_pass++;
    n_checks++; if (mem_m.o_MEM_addr !== 32'h0) $display("FAIL first_addr got %h expected 0", mem_m.o_MEM_addr); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (if_valid !== 1'b1) $display("FAIL pre_async_valid got %b expected 1", if_valid); else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_checks++; if (if_valid !== 1'b0 || if_inst !== InstNop)
      $display("FAIL async_rst got valid=%b inst=%h expected 0/%h", if_valid, if_inst, InstNop); else n_pass++;
  endtask

  task automatic test_stream();
    logic [7:0] vpat;
    bit ok;
    apply_reset(1);
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
    vpat = 8'h0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) idsue_wait = 1'b1;
      @(negedge clk);
      vpat[i] = if_valid;
      @(posedge clk); #1;
    end
    n_checks++; if (vpat !== 8'b0101_0100) $display("FAIL stream_valid_pattern got %b expected 01010100", vpat); else n_pass++;
    drain(10, ok);
    n_checks++; if (!ok) $display("FAIL stream_drain got %0d left expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_hold();
    bit stable;
    fetch_state_e st6;
    AddrBus pc10;
    logic v10;
    bit ok;
    apply_reset(1);
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
    stable = 1'b1;
    st6 = S_REQ; pc10 = 32'h0; v10 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 4)  idsue_wait = 1'b1;
      if (i == 9)  idsue_wait = 1'b0;
      if (i == 11) idsue_wait = 1'b1;
      @(negedge clk);
      if (i >= 4 && i <= 8 && (if_pc !== 32'h4 || if_inst !== inst_of(32'h4) || if_valid !== 1'b1))
        stable = 1'b0;
      if (i == 6) st6 = dbg_state;
      if (i == 10) begin pc10 = if_pc; v10 = if_valid; end
      @(posedge clk); #1;
    end
    n_checks++; if (st6 !== S_HOLD) $display("FAIL hold_state got %0d expected %0d", st6, S_HOLD); else n_pass++;
    n_checks++; if (!stable) $display("FAIL hold_frozen got changing output expected pc=4 held"); else n_pass++;
    n_checks++; if (pc10 !== 32'h8 || v10 !== 1'b1) $display("FAIL hold_release got pc=%h v=%b expected 8/1", pc10, v10); else n_pass++;
    drain(10, ok);
    n_checks++; if (!ok) $display("FAIL hold_drain got %0d left expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_redirect_resp();
    bit ok;
    apply_reset(3);
    push_exp(32'h100);
    @(posedge clk); #1;
    redirect = 1'b1;
    target   = 32'h100;
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_m.o_MEM_req !== 1'b0 || dbg_state !== S_RESP)
      $display("FAIL rdr_wait_resp got req=%b state=%0d expected 0/%0d", mem_m.o_MEM_req, dbg_state, S_RESP); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (mem_m.o_MEM_req !== 1'b1 || mem_m.o_MEM_addr !== 32'h100)
      $display("FAIL rdr_addr got req=%b addr=%h expected 1/100", mem_m.o_MEM_req, mem_m.o_MEM_addr); else n_pass++;
    n_checks++; if (if_valid !== 1'b0 || if_inst !== InstNop)
      $display("FAIL rdr_bubble got v=%b inst=%h expected 0/%h", if_valid, if_inst, InstNop); else n_pass++;
    @(posedge clk); #1;
    drain(40, ok);
    n_checks++; if (!ok) $display("FAIL rdr_drain got %0d left expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_redirect_wait();
    bit found;
    bit ok;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (dbg_state == S_HOLD) begin found = 1'b1; break; end
    end
    n_checks++; if (!found) $display("FAIL rdw_reach_hold got state=%0d expected %0d", dbg_state, S_HOLD); else n_pass++;
    n_checks++; if (if_valid !== 1'b1) $display("FAIL rdw_pre_valid got %b expected 1", if_valid); else n_pass++;
    redirect = 1'b1;
    target   = 32'h203;
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    n_checks++; if (if_inst !== InstNop || if_valid !== 1'b0)
      $display("FAIL rdw_flush got inst=%h v=%b expected %h/0", if_inst, if_valid, InstNop); else n_pass++;
    n_checks++; if (mem_m.o_MEM_req !== 1'b1 || mem_m.o_MEM_addr !== 32'h200)
      $display("FAIL rdw_addr got req=%b addr=%h expected 1/200", mem_m.o_MEM_req, mem_m.o_MEM_addr); else n_pass++;
    push_exp(32'h200); push_exp(32'h204);
    @(posedge clk); #1;
    idsue_wait = 1'b0;
    drain(40, ok);
    n_checks++; if (!ok) $display("FAIL rdw_drain got %0d left expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_wrap();
    apply_reset(1);
    idsue_wait = 1'b1;
    @(negedge clk);
    n_checks++; if (mem_w.o_MEM_req !== 1'b1 || mem_w.o_MEM_addr !== 32'hFFFF_FFFC)
      $display("FAIL wrap_first got req=%b addr=%h expected 1/fffffffc", mem_w.o_MEM_req, mem_w.o_MEM_addr); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (mem_w.o_MEM_req !== 1'b1 || mem_w.o_MEM_addr !== 32'h0)
      $display("FAIL wrap_second got req=%b addr=%h expected 1/0", mem_w.o_MEM_req, mem_w.o_MEM_addr); else n_pass++;
    n_checks++; if (w_if_pc !== 32'hFFFF_FFFC || w_if_valid !== 1'b1)
      $display("FAIL wrap_out got pc=%h v=%b expected fffffffc/1", w_if_pc, w_if_valid); else n_pass++;
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    logic [31:0] f10, s10;
    apply_reset(1);
    #1;
    n_checks++; if (perf_fetched !== 32'd0 || perf_stall !== 32'd0)
      $display("FAIL perf_reset got %0d/%0d expected 0/0", perf_fetched, perf_stall); else n_pass++;
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
    f10 = 32'h0; s10 = 32'h0;
    for (int i = 0; i < 11; i++) begin
      if (i == 4)  idsue_wait = 1'b1;
      if (i == 8)  idsue_wait = 1'b0;
      if (i == 10) idsue_wait = 1'b1;
      @(negedge clk);
      if (i == 10) begin f10 = perf_fetched; s10 = perf_stall; end
      @(posedge clk); #1;
    end
    n_checks++; if (f10 !== 32'd3) $display("FAIL perf_fetched got %0d expected 3", f10); else n_pass++;
    n_checks++; if (s10 !== 32'd4) $display("FAIL perf_stall got %0d expected 4", s10); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL perf_sb got %0d left expected 0", exp_q.size()); else n_pass++;
  endtask
`endif

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    test_reset();
    test_stream();
    test_hold();
    test_redirect_resp();
    test_redirect_wait();
    test_wrap();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000 (ZeroPc), meaning the first fetch address after reset.
REQ-002 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have rst  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have o_IF_pc  out  32  PC of the presented instruction (AddrBus).
REQ-005 SHALL have o_IF_inst  out  32  presented instruction (InstBus); InstNop when invalid.
REQ-006 SHALL have o_IF_valid  out  1  presented instruction is real, not a bubble.
REQ-007 SHALL have i_IDSUE_wait  in  1  decode stall; the downstream register holds while high.
REQ-008 SHALL have i_EX_redirect  in  1  single-cycle pulse: flush and fetch from i_EX_target.
REQ-009 SHALL have i_EX_target  in  32  redirect address; bits [1:0] are forced to zero.
REQ-010 SHALL have o_MEM_req  out  1 and o_MEM_addr  out  32, the fetch request and its word address.
REQ-011 SHALL have i_MEM_gnt  in  1  request accepted this cycle, and i_MEM_rvalid  in  1 with i_MEM_rdata  in  32 for the in-order response, at least 1 cycle after grant.

Function
REQ-012 SHALL keep at most one memory request outstanding.
REQ-013 SHALL implement states REQ, RESP and HOLD.
- REQ: o_MEM_req=1, o_MEM_addr=pc.
- REQ -> RESP on i_MEM_gnt; pc<=pc+4 (mod 2^32, wraps).
REQ-014 In RESP, on i_MEM_rvalid, SHALL load the output register (pc, rdata, valid=1) and go to REQ if the output register is free this cycle. Otherwise it SHALL store the data in a one-entry hold buffer and go to HOLD.
REQ-015 Output register free SHALL mean: o_IF_valid==0 or i_IDSUE_wait==0.
REQ-016 The output is consumed at each rising edge where i_IDSUE_wait==0. If no new data is loaded at that edge, the next cycle SHALL present a bubble: o_IF_inst=InstNop, o_IF_valid=0, o_IF_pc unchanged.
REQ-017 SHALL hold o_IF_pc, o_IF_inst and o_IF_valid stable while i_IDSUE_wait==1.
REQ-018 In HOLD, when the output becomes free, SHALL move the buffer into the output register and go to REQ.
REQ-019 i_EX_redirect SHALL take priority over all other events:
- pc<=target; output register <= bubble, even when i_IDSUE_wait==1; hold buffer dropped.
- The next state SHALL be REQ.
- If a request is outstanding, or is granted in the same cycle, the next state SHALL be RESP with a discard flag set.
REQ-020 In RESP with the discard flag set, SHALL drop the i_MEM_rvalid data, clear the flag and go to REQ.
REQ-021 SHALL deliver instructions in program order without loss or duplication.
- Steady-state throughput: one instruction per 2 cycles with 1-cycle memory latency.

Reset
REQ-022 While rst==0, SHALL force:
- state=REQ, pc=RESET_PC, discard=0, hold buffer empty;
- o_IF_pc=ZeroPc, o_IF_inst=InstNop, o_IF_valid=0, o_MEM_req=0.
REQ-023 SHALL assert the first o_MEM_req in the first cycle after rst deasserts.
- Reset mid-transaction abandons that transaction; a late i_MEM_rvalid is ignored while state==REQ.

Configuration
REQ-024 With FETCH_PERF_EN defined, SHALL add outputs o_PERF_fetched (32) and o_PERF_stall (32).
- o_PERF_fetched: count of valid instructions consumed.
- o_PERF_stall: count of cycles with o_IF_valid==1 and i_IDSUE_wait==1.
- Both are cleared by reset and wrap at 2^32.
REQ-025 Without FETCH_PERF_EN, these ports and counters SHALL be absent; function is otherwise identical.

Structure
REQ-026 AddrBus, InstBus, ZeroPc, InstNop (32'h0000_0013) and the state encodings SHALL live in the shared defines header.
REQ-027 SHALL be a single module with no sub-module; the hold buffer is an inline register set.

Verification
REQ-028 The bench SHALL cover: reset release, gnt=1, 1-cycle latency, rdata=i -> o_IF_pc 0,4,8 with o_IF_inst matching, valid pulses every 2nd cycle.
REQ-029 The bench SHALL cover: wait held high 5 cycles while a response arrives -> state HOLD, output frozen at pc 4, pc 8 delivered the cycle after wait drops.
REQ-030 The bench SHALL cover: redirect to 0x100 while in RESP -> in-flight response discarded, next o_MEM_addr 0x100, output bubble with valid=0.
REQ-031 The bench SHALL cover: redirect to 0x203 with wait=1 -> output flushed to InstNop, fetch address 0x200.
REQ-032 The bench SHALL cover: RESET_PC=32'hFFFF_FFFC -> second fetch address 0x0 (wrap).
REQ-033 The bench SHALL cover, with FETCH_PERF_EN: 3 instructions consumed, 4 stall cycles -> o_PERF_fetched=3, o_PERF_stall=4.
